execute_stage: RTL and testbench
================================

# execute_stage

Pipeline execute stage that sits directly upstream of the memory stage and produces its 75-bit EX/MEM register. It evaluates single-cycle ALU operations on already-forwarded operands and passes memory/write-back control through unchanged. It also owns the HI/LO registers and an iterative 32-cycle unsigned multiply/divide unit that stalls upstream while busy.

## Interface
- `XLEN`, 32: datapath width. All fixed bit positions below assume 32.
- `MD_CYCLES`, 32: number of busy cycles for MULTU/DIVU.
- **Clock and reset.** One clock. Reset is asynchronous and active-low.
  - `clk` in 1: rising-edge clock.
  - `rst_n` in 1: asynchronous, active-low reset.
- **Inputs.**
  - `in_valid` in 1: an instruction is presented this cycle.
  - `aluOp` in 4: operation code (see Operation).
  - `opA`, `opB` in 32: source operands. `opB` is already immediate-selected.
  - `shamt` in 5: shift amount.
  - `storeData` in 32: rt value for stores.
  - `writeReg` in 5: destination register.
  - `memRead`, `memWrite`, `memToReg`, `regWrite` in 1 each: control bits, passed through.
- **Outputs.**
  - `stall` out 1: upstream must hold its inputs; they are ignored this cycle.
  - `EXMEMReg` out 75, registered:
    - [31:0] result/address
    - [63:32] storeData
    - [68:64] writeReg
    - [70:69] always 0
    - [71] memRead
    - [72] memToReg
    - [73] memWrite
    - [74] regWrite

## Operation
- **aluOp codes** (slt is signed, sltu unsigned; shifts apply to `opB`):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA by `shamt`
  - 11 MULTU, 12 DIVU
  - 13 MFHI, 14 MFLO
  - 15 LUI (`opB<<16`)
- All arithmetic is modulo 2^32. No overflow trap.
- **Accept.** An instruction is accepted on an edge where `in_valid`=1 and `stall`=0. `EXMEMReg` loads {regWrite, memWrite, memToReg, memRead, 2'b00, writeReg, storeData, result}.
- **Bubble.** Loaded when not accepted: all 75 bits 0.
- **MULTU/DIVU** (accepted while IDLE):
  - Latch `opA`/`opB`, load the counter with `MD_CYCLES`, enter BUSY.
  - `EXMEMReg` gets a bubble; the instruction writes no GPR.
- **State machine.**
  - IDLE→BUSY on accepted MULTU/DIVU.
  - BUSY: counter decrements each edge. On the edge where it reaches 0, write HI/LO and go to IDLE.
  - `stall` = (state==BUSY). It is combinational from state, so `stall`=0 on the issue cycle.
- **MULTU result.** {HI,LO} = opA×opB (64-bit unsigned).
- **DIVU result.** LO = quotient, HI = remainder.
  - Divide by zero: LO=0xFFFFFFFF, HI=opA. No exception.
- **MFHI/MFLO.** Can only be accepted in IDLE, so they always return completed HI/LO.
- **Back-to-back MULTU/DIVU.** The second is held by `stall` and issued on the first non-stall edge.

## Timing
- **Reset** (async, any state): `EXMEMReg`=0, HI=LO=0, state IDLE, counter 0, `stall`=0. An in-flight mul/div is discarded and HI/LO remain 0.
- **ALU latency.** 1 cycle: `EXMEMReg` is valid after the accepting edge.
- **MULTU/DIVU issued at edge T:**
  - `stall`=1 from after edge T through edge T+32.
  - HI/LO are written at edge T+32.
  - `stall`=0 after T+32.
  - A held instruction is accepted at edge T+33.
- **While `stall`=1:** `EXMEMReg` is a bubble every edge and inputs are ignored.
- **`in_valid`=0:** bubble. HI/LO are unchanged.

## Structure
- Package `exec_pkg`:
  - aluOp localparams
  - `EXMEMReg` field positions and width 75
  - `MD_CYCLES`
- Sub-module `mul_div_unit`:
  - Shift-add multiplier and restoring divider sharing a 64-bit working register.
  - Ports: start, isDiv, a, b, busy, done, hi, lo.
  - Owns the counter.
  - The top level owns the HI/LO registers, the `EXMEMReg` register and the stall logic.

## Test plan
- **ADD pass-through.** ADD opA=5, opB=7, writeReg=3, regWrite=1 → next cycle `EXMEMReg`[31:0]=12, [68:64]=3, [74]=1, [73:71]=0.
- **SLT vs SLTU.** SLT opA=0xFFFFFFFF, opB=1 → result 1. SLTU with the same operands → result 0. SRA of 0x80000000 by 4 → 0xF8000000.
- **Multiply then read.** MULTU 0xFFFFFFFF×0xFFFFFFFF, then MFLO presented the next cycle:
  - `stall` high for exactly 32 cycles.
  - MFLO is accepted at T+33 → result 0x00000001.
  - A following MFHI → 0xFFFFFFFE.
- **Divide, including by zero.** DIVU 100/7 → LO=14, HI=2. DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- **Reset mid-divide.** Assert `rst_n`=0 at cycle 10 of a DIVU → immediately `stall`=0 and `EXMEMReg`=0. After release, MFHI → 0.
- **Store pass-through.** Store with opA+opB=0x100, storeData=0x01010100, memWrite=1 → [31:0]=0x100, [63:32]=0x01010100, [73]=1, [70:69]=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage and its multiply/divide unit.
package exec_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MD_CYCLES = 32;
  localparam int unsigned CNT_W     = $clog2(MD_CYCLES + 1);
  localparam int unsigned OP_W      = 4;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned EXMEM_W   = 75;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_NOR   = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'd9;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'd10;
  localparam logic [OP_W-1:0] ALU_MULTU = 4'd11;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'd12;
  localparam logic [OP_W-1:0] ALU_MFHI  = 4'd13;
  localparam logic [OP_W-1:0] ALU_MFLO  = 4'd14;
  localparam logic [OP_W-1:0] ALU_LUI   = 4'd15;

  // EX/MEM register layout, MSB first: [74] regWrite ... [31:0] result
  typedef struct packed {
    logic             reg_write;   // [74]
    logic             mem_write;   // [73]
    logic             mem_to_reg;  // [72]
    logic             mem_read;    // [71]
    logic [1:0]       rsvd;        // [70:69]
    logic [REG_W-1:0] write_reg;   // [68:64]
    logic [XLEN-1:0]  store_data;  // [63:32]
    logic [XLEN-1:0]  result;      // [31:0]
  } exmem_t;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute handshake plus the EX/MEM register output.
interface execute_stage_if;
  import exec_pkg::*;

  logic                 in_valid;
  logic [OP_W-1:0]      aluOp;
  logic [XLEN-1:0]      opA;
  logic [XLEN-1:0]      opB;
  logic [4:0]           shamt;
  logic [XLEN-1:0]      storeData;
  logic [REG_W-1:0]     writeReg;
  logic                 memRead;
  logic                 memWrite;
  logic                 memToReg;
  logic                 regWrite;
  logic                 stall;
  logic [EXMEM_W-1:0]   EXMEMReg;

  modport master (
    output in_valid, aluOp, opA, opB, shamt, storeData, writeReg,
           memRead, memWrite, memToReg, regWrite,
    input  stall, EXMEMReg
  );

  modport slave (
    input  in_valid, aluOp, opA, opB, shamt, storeData, writeReg,
           memRead, memWrite, memToReg, regWrite,
    output stall, EXMEMReg
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// hi/lo present the value the working register takes on this edge, so the
// owner can capture the final result on the edge where done is high.
module mul_div_unit
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            isDiv,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN:0]     mul_sum_c;
  logic [XLEN:0]     div_up_c;
  logic              div_ge_c;
  logic [2*XLEN-1:0] step_c;

  // One iteration: shift-add for multiply, shift-compare-subtract for divide
  always_comb begin
    mul_sum_c = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    div_up_c  = acc_q[2*XLEN-1:XLEN-1];
    div_ge_c  = div_up_c >= {1'b0, b_q};
    step_c    = {mul_sum_c, acc_q[XLEN-1:1]};
    if (div_q) begin
      if (div_ge_c) step_c = {div_up_c[XLEN-1:0] - b_q, acc_q[XLEN-2:0], 1'b1};
      else          step_c = {div_up_c[XLEN-1:0],       acc_q[XLEN-2:0], 1'b0};
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign hi   = step_c[2*XLEN-1:XLEN];
  assign lo   = step_c[XLEN-1:0];

  // Working register and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      div_q <= isDiv;
      cnt_q <= CNT_W'(MD_CYCLES);
    end else if (busy) begin
      acc_q <= step_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, HI/LO registers, stall while mul/div runs.
module execute_stage
  import exec_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  execute_stage_if.slave ex
);

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] hi_q, lo_q;
  exmem_t          exmem_q, exmem_d;

  logic            accept_c;
  logic            is_md_c;
  logic            md_start_c;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_hi, md_lo;
  logic [XLEN-1:0] alu_res_c;

  assign ex.stall   = (state_q == ST_BUSY);
  assign accept_c   = ex.in_valid && !ex.stall;
  assign is_md_c    = (ex.aluOp == ALU_MULTU) || (ex.aluOp == ALU_DIVU);
  assign md_start_c = accept_c && is_md_c;
  assign ex.EXMEMReg = exmem_q;

  mul_div_unit u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start_c),
    .isDiv (ex.aluOp == ALU_DIVU),
    .a     (ex.opA),
    .b     (ex.opB),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Single-cycle ALU on forwarded operands
  always_comb begin
    alu_res_c = '0;
    unique case (ex.aluOp)
      ALU_ADD:  alu_res_c = ex.opA + ex.opB;
      ALU_SUB:  alu_res_c = ex.opA - ex.opB;
      ALU_AND:  alu_res_c = ex.opA & ex.opB;
      ALU_OR:   alu_res_c = ex.opA | ex.opB;
      ALU_XOR:  alu_res_c = ex.opA ^ ex.opB;
      ALU_NOR:  alu_res_c = ~(ex.opA | ex.opB);
      ALU_SLT:  alu_res_c = XLEN'($signed(ex.opA) < $signed(ex.opB));
      ALU_SLTU: alu_res_c = XLEN'(ex.opA < ex.opB);
      ALU_SLL:  alu_res_c = ex.opB << ex.shamt;
      ALU_SRL:  alu_res_c = ex.opB >> ex.shamt;
      ALU_SRA:  alu_res_c = XLEN'($signed(ex.opB) >>> ex.shamt);
      ALU_MFHI: alu_res_c = hi_q;
      ALU_MFLO: alu_res_c = lo_q;
      ALU_LUI:  alu_res_c = {ex.opB[15:0], 16'h0000};
      default:  alu_res_c = '0;
    endcase
  end

  // Next state and EX/MEM payload; mul/div issue and non-accepts are bubbles
  always_comb begin
    state_d = state_q;
    exmem_d = '0;
    unique case (state_q)
      ST_IDLE: if (md_start_c) state_d = ST_BUSY;
      ST_BUSY: if (md_done || !md_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept_c && !is_md_c) begin
      exmem_d.reg_write  = ex.regWrite;
      exmem_d.mem_write  = ex.memWrite;
      exmem_d.mem_to_reg = ex.memToReg;
      exmem_d.mem_read   = ex.memRead;
      exmem_d.write_reg  = ex.writeReg;
      exmem_d.store_data = ex.storeData;
      exmem_d.result     = alu_res_c;
    end
  end

  // State, EX/MEM and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      exmem_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      exmem_q <= exmem_d;
      if (state_q == ST_BUSY && md_done) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed EX/MEM expectations.
module tb_execute_stage;
  import exec_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;

  execute_stage_if ex_if ();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] mk(input logic rw, input logic mw, input logic m2r,
                                     input logic mr, input logic [4:0] wr,
                                     input logic [31:0] sd, input logic [31:0] res);
    mk = {rw, mw, m2r, mr, 2'b00, wr, sd, res};
  endfunction

  task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] sd,
                       input logic [4:0] wr, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    ex_if.in_valid  = v;
    ex_if.aluOp     = op;
    ex_if.opA       = a;
    ex_if.opB       = b;
    ex_if.shamt     = sh;
    ex_if.storeData = sd;
    ex_if.writeReg  = wr;
    ex_if.memRead   = mr;
    ex_if.memWrite  = mw;
    ex_if.memToReg  = m2r;
    ex_if.regWrite  = rw;
  endtask

  // Tick until stall drops; returns number of samples with stall high
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (ex_if.stall === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    if (ex_if.stall !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL stall_timeout observed=%0b expected=0", ex_if.stall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_exmem", ex_if.EXMEMReg, 75'd0);
    check("reset_stall", 75'(ex_if.stall), 75'd0);
    tick();
    rst_n = 1'b1;

    // ADD pass-through
    drive(1'b1, ALU_ADD, 32'd5, 32'd7, 5'd0, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("add", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd0, 32'd12));

    // SLT signed vs SLTU unsigned
    drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("slt", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'd0, 32'd1));
    drive(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sltu", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'd0, 32'd0));

    // SRA sign-extends opB
    drive(1'b1, ALU_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sra", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'd0, 32'hF800_0000));

    // SUB wraps, NOR, LUI
    drive(1'b1, ALU_SUB, 32'd3, 32'd5, 5'd0, 32'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sub", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'd0, 32'hFFFF_FFFE));
    drive(1'b1, ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("nor", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'd0, 32'hF0F0_FF00));
    drive(1'b1, ALU_LUI, 32'd0, 32'h0000_1234, 5'd0, 32'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lui", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 32'h1234_0000));

    // Store pass-through
    drive(1'b1, ALU_ADD, 32'h0000_00F0, 32'h0000_0010, 5'd0, 32'h0101_0100, 5'd0,
          1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("store", ex_if.EXMEMReg, mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0101_0100, 32'h100));

    // in_valid low gives a bubble
    drive(1'b0, ALU_ADD, 32'd1, 32'd1, 5'd0, 32'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("bubble", ex_if.EXMEMReg, 75'd0);

    // MULTU max*max then MFLO held behind the stall
    drive(1'b1, ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("multu_issue_bubble", ex_if.EXMEMReg, 75'd0);
    check("multu_stall_on", 75'(ex_if.stall), 75'd1);
    drive(1'b1, ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(n);
    check("multu_stall_len", 75'(n), 75'd32);
    check("multu_held_bubble", ex_if.EXMEMReg, 75'd0);
    tick();
    check("mflo_mul", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'd0, 32'h0000_0001));
    drive(1'b1, ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mfhi_mul", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'd0, 32'hFFFF_FFFE));

    // DIVU 100/7
    drive(1'b1, ALU_DIVU, 32'd100, 32'd7, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(n);
    check("divu_stall_len", 75'(n), 75'd32);
    tick();
    check("mflo_div", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'd0, 32'd14));
    drive(1'b1, ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mfhi_div", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'd0, 32'd2));

    // DIVU by zero
    drive(1'b1, ALU_DIVU, 32'd9, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(n);
    tick();
    check("mflo_div0", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd14, 32'd0, 32'hFFFF_FFFF));
    drive(1'b1, ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mfhi_div0", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 32'd0, 32'd9));

    // Reset in the middle of a divide discards it and clears HI/LO
    drive(1'b1, ALU_DIVU, 32'd1000, 32'd3, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("mid_div_stall", 75'(ex_if.stall), 75'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_stall", 75'(ex_if.stall), 75'd0);
    check("rst_exmem", ex_if.EXMEMReg, 75'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mfhi_after_rst", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd16, 32'd0, 32'd0));
    check("stall_after_rst", 75'(ex_if.stall), 75'd0);
    drive(1'b1, ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mflo_after_rst", ex_if.EXMEMReg, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd17, 32'd0, 32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
